// File: rtl/exu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// exu_seq_ctrl
//   Multi-cycle sequencer for the single-issue core. It fetches one instruction
//   at a time, holds it in the instruction register for the decoder and EXU,
//   captures the EXU write-back and commits it to the register file. It owns
//   the PC, the retire counter and the halt/error status.
//
// Ports
//   clk, rst                      clock (posedge), async active-high reset
//   start                         begin execution from pc (IDLE only)
//   imem_req/imem_addr            fetch request (whole FETCH state), address = pc
//   imem_rvalid/imem_rdata        fetch response
//   inst                          instruction register to the decoder
//   dec_command/dec_halt          decoder results (01 = addi-type)
//   exu_wen/exu_waddr/exu_wdata   EXU write-back
//   rf_wen/rf_waddr/rf_wdata      regfile write port (rf_wen one cycle, in WB)
//   pc, retire, instret           program counter, retire pulse, retire count
//   busy, halted, error           status (FETCH/EXEC/WB, HALT, ERROR)
// -----------------------------------------------------------------------------
module exu_seq_ctrl #(
  parameter int          ADDR_WIDTH    = 5,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           inst,
  input  logic [1:0]            dec_command,
  input  logic                  dec_halt,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_waddr,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [31:0]           pc,
  output logic                  retire,
  output logic [31:0]           instret,
  output logic                  busy,
  output logic                  halted,
  output logic                  error
);

  // Timer must hold FETCH_TIMEOUT itself: it steps once more on the cycle
  // that moves to ERROR.
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(FETCH_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [TW-1:0]         timer_r;
  logic [31:0]           pc_r;
  logic [31:0]           inst_r;
  logic [31:0]           instret_r;
  logic                  wen_q_r;
  logic                  halt_q_r;
  logic [ADDR_WIDTH-1:0] waddr_q_r;
  logic [DATA_WIDTH-1:0] wdata_q_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. On the last allowed FETCH cycle a same-cycle rvalid
  // still wins over the timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_FETCH: begin
        if (imem_rvalid)                state_s = S_EXEC;
        else if (timer_r == TIMER_LAST) state_s = S_ERROR;
        else                            state_s = S_FETCH;
      end
      S_EXEC: state_s = S_WB;
      S_WB: begin
        if (halt_q_r) state_s = S_HALT;
        else          state_s = S_FETCH;
      end
      S_HALT:  state_s = S_HALT;
      S_ERROR: state_s = S_ERROR;
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath: instruction register, fetch timer, write-back capture, PC and
  // retire counter. Reset drops any captured write before it can commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r   <= '0;
      pc_r      <= RESET_PC;
      inst_r    <= 32'd0;
      instret_r <= 32'd0;
      wen_q_r   <= 1'b0;
      halt_q_r  <= 1'b0;
      waddr_q_r <= '0;
      wdata_q_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          timer_r <= '0;
        end
        S_FETCH: begin
          if (imem_rvalid) inst_r  <= imem_rdata;
          else             timer_r <= timer_r + TIMER_ONE;
        end
        S_EXEC: begin
          wen_q_r   <= exu_wen & (dec_command == 2'b01) & ~dec_halt;
          halt_q_r  <= dec_halt;
          waddr_q_r <= exu_waddr;
          wdata_q_r <= exu_wdata;
        end
        S_WB: begin
          instret_r <= instret_r + 32'd1;
          timer_r   <= '0;
          if (!halt_q_r) pc_r <= pc_r + 32'd4;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from registered state only, so strobes are glitch-free.
  always_comb begin
    imem_req  = (state_r == S_FETCH);
    imem_addr = pc_r;
    inst      = inst_r;
    rf_wen    = (state_r == S_WB) & wen_q_r;
    rf_waddr  = waddr_q_r;
    rf_wdata  = wdata_q_r;
    pc        = pc_r;
    retire    = (state_r == S_WB);
    instret   = instret_r;
    busy      = (state_r == S_FETCH) | (state_r == S_EXEC) | (state_r == S_WB);
    halted    = (state_r == S_HALT);
    error     = (state_r == S_ERROR);
  end

endmodule

// File: tb/tb_exu_seq_ctrl.sv
module tb_exu_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [1:0]  dec_command;
  logic        dec_halt;
  logic        exu_wen;
  logic [4:0]  exu_waddr;
  logic [31:0] exu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        busy;
  logic        halted;
  logic        error;

  int checks   = 0;
  int failures = 0;

  exu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .dec_command(dec_command), .dec_halt(dec_halt),
    .exu_wen(exu_wen), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .retire(retire), .instret(instret),
    .busy(busy), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  // advance one active edge, then settle 1 time unit
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    dec_command = 2'b00; dec_halt = 1'b0; exu_wen = 1'b0;
    exu_waddr = 5'd0; exu_wdata = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_req, rf_wen, retire, busy, halted, error} !== 6'b000000 ||
        pc !== RST_PC || inst !== 32'd0 || instret !== 32'd0 ||
        rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: flags=%b pc=%h inst=%h instret=%0d, expected flags=000000 pc=%h rest 0",
               {imem_req, rf_wen, retire, busy, halted, error}, pc, inst, instret, RST_PC);
    end
  endtask

  // addi x1,x0,5 with rvalid in the same FETCH cycle
  task automatic test_single_addi();
    start = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();  // -> FETCH
    start = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || busy !== 1'b1) begin
      failures++;
      $display("FAIL t1_fetch: req=%b addr=%h busy=%b, expected 1 %h 1", imem_req, imem_addr, busy, RST_PC);
    end
    tick();  // -> EXEC
    checks++;
    if (inst !== 32'h0050_0093 || imem_req !== 1'b0 || rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL t1_exec: inst=%h req=%b wen=%b, expected 00500093 0 0", inst, imem_req, rf_wen);
    end
    imem_rvalid = 1'b0;
    dec_command = 2'b01; exu_wen = 1'b1; exu_waddr = 5'd1; exu_wdata = 32'd5;
    tick();  // -> WB
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'd5 || retire !== 1'b1 || pc !== RST_PC) begin
      failures++;
      $display("FAIL t1_wb: wen=%b waddr=%0d wdata=%0d retire=%b pc=%h, expected 1 1 5 1 %h",
               rf_wen, rf_waddr, rf_wdata, retire, pc, RST_PC);
    end
    exu_wen = 1'b0;
    tick();  // -> FETCH @ +4
    checks++;
    if (pc !== 32'h8000_0004 || instret !== 32'd1 || retire !== 1'b0 || rf_wen !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL t1_commit: pc=%h instret=%0d retire=%b wen=%b req=%b, expected 80000004 1 0 0 1",
               pc, instret, retire, rf_wen, imem_req);
    end
  endtask

  // rvalid delayed 4 cycles; request must stay up with a stable address
  task automatic test_delayed_fetch();
    int bad = 0;
    imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0004) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0004) begin
      failures++;
      $display("FAIL t2_req_hold: bad_cycles=%0d req=%b addr=%h, expected 0 1 80000004", bad, imem_req, imem_addr);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h0090_0113;  // addi x2,x0,9
    tick();  // -> EXEC
    imem_rvalid = 1'b0;
    dec_command = 2'b01; exu_wen = 1'b1; exu_waddr = 5'd2; exu_wdata = 32'd9;
    checks++;
    if (inst !== 32'h0090_0113 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL t2_exec: inst=%h req=%b, expected 00900113 0", inst, imem_req);
    end
    tick();  // -> WB
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'd9 || retire !== 1'b1) begin
      failures++;
      $display("FAIL t2_wb: wen=%b waddr=%0d wdata=%0d retire=%b, expected 1 2 9 1", rf_wen, rf_waddr, rf_wdata, retire);
    end
    exu_wen = 1'b0;
    tick();  // -> FETCH @ +8
    checks++;
    if (pc !== 32'h8000_0008 || instret !== 32'd2) begin
      failures++;
      $display("FAIL t2_commit: pc=%h instret=%0d, expected 80000008 2", pc, instret);
    end
  endtask

  // halt instruction at 80000008; start must be ignored afterwards
  task automatic test_halt();
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
    tick();  // -> EXEC
    imem_rvalid = 1'b0;
    dec_halt = 1'b1; dec_command = 2'b01; exu_wen = 1'b1; exu_waddr = 5'd3; exu_wdata = 32'd1;
    tick();  // -> WB
    checks++;
    if (retire !== 1'b1 || rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL t5_wb: retire=%b wen=%b, expected 1 0", retire, rf_wen);
    end
    dec_halt = 1'b0; exu_wen = 1'b0;
    tick();  // -> HALT
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 32'h8000_0008 || instret !== 32'd3 || retire !== 1'b0) begin
      failures++;
      $display("FAIL t5_halt: halted=%b busy=%b pc=%h instret=%0d retire=%b, expected 1 0 80000008 3 0",
               halted, busy, pc, instret, retire);
    end
    start = 1'b1; imem_rvalid = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h8000_0008 || instret !== 32'd3) begin
      failures++;
      $display("FAIL t5_start_ignored: halted=%b req=%b pc=%h instret=%0d, expected 1 0 80000008 3",
               halted, imem_req, pc, instret);
    end
    start = 1'b0; imem_rvalid = 1'b0;
  endtask

  // 16 FETCH cycles without rvalid -> ERROR; rvalid on the 16th wins
  task automatic test_timeout();
    do_reset();
    start = 1'b1;
    tick();  // -> FETCH
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (busy !== 1'b1 || error !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL t3_before_timeout: busy=%b error=%b req=%b, expected 1 0 1", busy, error, imem_req);
    end
    tick();  // 16th cycle without rvalid
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL t3_timeout: error=%b busy=%b req=%b, expected 1 0 0", error, busy, imem_req);
    end
    imem_rvalid = 1'b1; start = 1'b1;
    tick();
    tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || inst !== 32'd0) begin
      failures++;
      $display("FAIL t3_error_sticky: error=%b busy=%b inst=%h, expected 1 0 0", error, busy, inst);
    end
    do_reset();
    start = 1'b1;
    tick();  // -> FETCH
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0070_0013;  // addi x0,x0,7
    tick();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || imem_req !== 1'b0 || inst !== 32'h0070_0013) begin
      failures++;
      $display("FAIL t3_rvalid_wins: error=%b busy=%b req=%b inst=%h, expected 0 1 0 00700013",
               error, busy, imem_req, inst);
    end
    imem_rvalid = 1'b0;
  endtask

  // continues from EXEC of addi x0,x0,7, then an unsupported command
  task automatic test_no_write();
    dec_command = 2'b01; exu_wen = 1'b0; exu_waddr = 5'd0; exu_wdata = 32'd7;
    tick();  // -> WB
    checks++;
    if (rf_wen !== 1'b0 || retire !== 1'b1) begin
      failures++;
      $display("FAIL t4_x0_wb: wen=%b retire=%b, expected 0 1", rf_wen, retire);
    end
    tick();  // -> FETCH
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0000;
    tick();  // -> EXEC
    imem_rvalid = 1'b0;
    dec_command = 2'b00; exu_wen = 1'b1; exu_waddr = 5'd3; exu_wdata = 32'd123;
    tick();  // -> WB
    checks++;
    if (rf_wen !== 1'b0 || retire !== 1'b1) begin
      failures++;
      $display("FAIL t4_unsup_wb: wen=%b retire=%b, expected 0 1", rf_wen, retire);
    end
    exu_wen = 1'b0;
    tick();
    checks++;
    if (instret !== 32'd2 || pc !== 32'h8000_0008) begin
      failures++;
      $display("FAIL t4_count: instret=%0d pc=%h, expected 2 80000008", instret, pc);
    end
  endtask

  // async reset asserted between edges while in EXEC
  task automatic test_reset_mid_exec();
    do_reset();
    start = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();  // -> FETCH
    start = 1'b0;
    tick();  // -> EXEC
    imem_rvalid = 1'b0;
    dec_command = 2'b01; exu_wen = 1'b1; exu_waddr = 5'd1; exu_wdata = 32'd5;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rf_wen !== 1'b0 || retire !== 1'b0 || pc !== RST_PC ||
        inst !== 32'd0 || instret !== 32'd0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++;
      $display("FAIL t6_async_clear: busy=%b wen=%b retire=%b pc=%h inst=%h instret=%0d, expected 0 0 0 %h 0 0",
               busy, rf_wen, retire, pc, inst, instret, RST_PC);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rf_wen !== 1'b0 || retire !== 1'b0 || busy !== 1'b0 || instret !== 32'd0 || pc !== RST_PC) begin
      failures++;
      $display("FAIL t6_no_commit: wen=%b retire=%b busy=%b instret=%0d pc=%h, expected 0 0 0 0 %h",
               rf_wen, retire, busy, instret, pc, RST_PC);
    end
    exu_wen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_addi();
    test_delayed_fetch();
    test_halt();
    test_timeout();
    test_no_write();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
